mul16_seq: RTL and testbench

//   16x16 unsigned shift-and-add multiplier, 32-bit product; one partial-product add per clock.

---
 rtl/mul16_pkg.sv | 15 +
 rtl/adder_cla16.sv | 54 +++++
 rtl/mul16_seq.sv | 91 +++++++++
 tb/tb_mul16_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul16_pkg.sv
// rtl/mul16_pkg.sv - shared widths, iteration limit and controller states for mul16_seq
package mul16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_cla16.sv
// rtl/adder_cla16.sv - combinational 16-bit carry-lookahead adder, four 4-bit lookahead groups
module adder_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;

        for (int j = 0; j < 4; j++) begin
            grp_p[j] = &p[4*j +: 4];
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end

        // Second lookahead level: group carries resolved without rippling through groups
        grp_c[0] = cin;
        grp_c[1] = grp_g[0] | (grp_p[0] & cin);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

        for (int j = 0; j < 4; j++) begin
            c[4*j] = grp_c[j];
            for (int k = 1; k < 4; k++) begin
                c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
            end
        end

        sum  = p ^ c;
        cout = grp_c[4];
    end

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - 16x16 unsigned shift-and-add multiplier, one add per clock (MUL16_ZERO_BYPASS_EN: zero-operand shortcut)
module mul16_seq
    import mul16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     step_sum;

    adder_cla16 u_adder (
        .a    (p_hi_q),
        .b    (m_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        step_sum = p_lo_q[0] ? {add_cout, add_sum} : {1'b0, p_hi_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = a;
                    p_lo_d  = b;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MUL16_ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        p_lo_d  = '0;
                        state_d = DONE;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Carry-out lands in the product MSB as the accumulator shifts right
                {p_hi_d, p_lo_d} = {step_sum, p_lo_q[WIDTH-1:1]};
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - table-driven and sequence checks for mul16_seq (honours MUL16_ZERO_BYPASS_EN)
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_vec = 0;
    int n_err = 0;

`ifdef MUL16_ZERO_BYPASS_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 17;
    localparam int ZERO_BUSY = 16;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [10];

    mul16_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // i counts cycles after the accepting edge: i==17 is cycle k+17
    task automatic wait_done(input int limit, output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          lat;
        int          bc;
        int          d1;
        int          d2;
        int          n_done;
        logic [31:0] p1;
        logic [31:0] p2;
        logic        busy18;
        logic        done18;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[3] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
        vecs[4] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[5] = '{16'hFFFF, 16'h8000, 32'h7FFF_8000};
        vecs[6] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
        vecs[7] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
        vecs[8] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        vecs[9] = '{16'hABCD, 16'h0000, 32'h0000_0000};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            logic zero;
            zero = (vecs[v].a == 16'h0) || (vecs[v].b == 16'h0);
            start_op(vecs[v].a, vecs[v].b);
            wait_done(40, lat, bc);
            check($sformatf("vec%0d_product", v), product, vecs[v].p);
            check($sformatf("vec%0d_latency", v), 32'(lat), zero ? 32'(ZERO_LAT) : 32'd17);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bc), zero ? 32'(ZERO_BUSY) : 32'd16);
            tick();
            check($sformatf("vec%0d_done_pulse", v), 32'(done), 32'd0);
            tick();
            check($sformatf("vec%0d_product_hold", v), product, vecs[v].p);
        end

        // start pulsed while busy must not re-capture operands
        start_op(16'h1234, 16'h0010);
        repeat (4) tick();
        a     = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, lat, bc);
        check("ignore_start_latency", 32'(lat), 32'd12);
        check("ignore_start_product", product, 32'h0001_2340);
        tick();

        // reset mid-run
        start_op(16'h1234, 16'h0010);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", product, 32'd0);
        start_op(16'h0002, 16'h0007);
        wait_done(40, lat, bc);
        check("after_rst_product", product, 32'h0000_000E);
        check("after_rst_latency", 32'(lat), 32'd17);
        tick();

        // back-to-back runs with start held through DONE
        a      = 16'h0100;
        b      = 16'h0100;
        start  = 1'b1;
        tick();
        a      = 16'h8000;
        b      = 16'h0002;
        d1     = -1;
        d2     = -1;
        n_done = 0;
        p1     = '0;
        p2     = '0;
        busy18 = 1'b0;
        done18 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                n_done++;
                if (d1 < 0) begin
                    d1 = i;
                    p1 = product;
                end else if (d2 < 0) begin
                    d2 = i;
                    p2 = product;
                end
            end
            if (i == 18) begin
                start  = 1'b0;
                busy18 = busy;
                done18 = done;
            end
            tick();
        end
        check("b2b_first_done", 32'(d1), 32'd17);
        check("b2b_first_product", p1, 32'h0001_0000);
        check("b2b_no_gap_busy", 32'(busy18), 32'd1);
        check("b2b_single_done", 32'(done18), 32'd0);
        check("b2b_second_done", 32'(d2), 32'd34);
        check("b2b_second_product", p2, 32'h0001_0000);
        check("b2b_done_count", 32'(n_done), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
